axi4_rd_arbiter: RTL and testbench

Two-to-one AXI4 read-channel arbiter between the core's fetch and load paths and the single SoC AXI4 port. Port s0 takes the instruction-fetch master's AR/R channels; port s1 takes the data master's. One read transaction is outstanding at a time: the grant is held from AR acceptance through the RLAST beat, then released. Write channels do not pass through this block.

---
 rtl/axi4_rd_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_arbiter.sv
// Two-to-one AXI4 read-channel arbiter: s0 (instruction fetch) and s1 (data)
// share one SoC AXI4 read port, with a single transaction outstanding.
// The grant is taken in IDLE and held from AR acceptance through the RLAST beat.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on contention);
// when undefined, s1 wins contention (fixed priority).
module axi4_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    // Port s0: instruction fetch
    input  logic [ID_W-1:0]   s0_ARID,
    input  logic [ADDR_W-1:0] s0_ARADDR,
    input  logic [7:0]        s0_ARLEN,
    input  logic [2:0]        s0_ARSIZE,
    input  logic [1:0]        s0_ARBURST,
    input  logic              s0_ARVALID,
    output logic              s0_ARREADY,
    output logic [ID_W-1:0]   s0_RID,
    output logic [DATA_W-1:0] s0_RDATA,
    output logic [1:0]        s0_RRESP,
    output logic              s0_RLAST,
    output logic              s0_RVALID,
    input  logic              s0_RREADY,

    // Port s1: data
    input  logic [ID_W-1:0]   s1_ARID,
    input  logic [ADDR_W-1:0] s1_ARADDR,
    input  logic [7:0]        s1_ARLEN,
    input  logic [2:0]        s1_ARSIZE,
    input  logic [1:0]        s1_ARBURST,
    input  logic              s1_ARVALID,
    output logic              s1_ARREADY,
    output logic [ID_W-1:0]   s1_RID,
    output logic [DATA_W-1:0] s1_RDATA,
    output logic [1:0]        s1_RRESP,
    output logic              s1_RLAST,
    output logic              s1_RVALID,
    input  logic              s1_RREADY,

    // SoC side
    output logic [ID_W:0]     m_ARID,
    output logic [ADDR_W-1:0] m_ARADDR,
    output logic [7:0]        m_ARLEN,
    output logic [2:0]        m_ARSIZE,
    output logic [1:0]        m_ARBURST,
    output logic              m_ARLOCK,
    output logic [3:0]        m_ARCACHE,
    output logic [2:0]        m_ARPROT,
    output logic [3:0]        m_ARQOS,
    output logic [3:0]        m_ARREGION,
    output logic              m_ARVALID,
    input  logic              m_ARREADY,
    input  logic [ID_W:0]     m_RID,
    input  logic [DATA_W-1:0] m_RDATA,
    input  logic [1:0]        m_RRESP,
    input  logic              m_RLAST,
    input  logic              m_RVALID,
    output logic              m_RREADY
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   arb_pick;

    // Return routing uses grant only; the ID tag bit is never inspected.
    logic   unused_rid_msb;
    assign unused_rid_msb = m_RID[ID_W];

    assign m_ARLOCK   = 1'b0;
    assign m_ARCACHE  = 4'd0;
    assign m_ARPROT   = 3'd0;
    assign m_ARQOS    = 4'd0;
    assign m_ARREGION = 4'd0;

    // Arbitration decision among requesters present in IDLE
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (s0_ARVALID && s1_ARVALID) begin
            arb_pick = ~last_grant_q;
        end else begin
            arb_pick = s1_ARVALID;
        end
`else
        arb_pick = s1_ARVALID;
`endif
    end

    // State, grant and last-grant registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (s0_ARVALID || s1_ARVALID) begin
                    grant_d = arb_pick;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (m_ARVALID && m_ARREADY) begin
                    last_grant_d = grant_q;
                    state_d      = StData;
                end
            end
            StData: begin
                if (m_RVALID && m_RREADY && m_RLAST) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: AR/R routed combinationally to the granted port only
    always_comb begin
        m_ARID     = '0;
        m_ARADDR   = '0;
        m_ARLEN    = '0;
        m_ARSIZE   = '0;
        m_ARBURST  = '0;
        m_ARVALID  = 1'b0;
        m_RREADY   = 1'b0;
        s0_ARREADY = 1'b0;
        s1_ARREADY = 1'b0;
        s0_RID     = '0;
        s0_RDATA   = '0;
        s0_RRESP   = '0;
        s0_RLAST   = 1'b0;
        s0_RVALID  = 1'b0;
        s1_RID     = '0;
        s1_RDATA   = '0;
        s1_RRESP   = '0;
        s1_RLAST   = 1'b0;
        s1_RVALID  = 1'b0;
        case (state_q)
            StAddr: begin
                if (grant_q) begin
                    m_ARID     = {1'b1, s1_ARID};
                    m_ARADDR   = s1_ARADDR;
                    m_ARLEN    = s1_ARLEN;
                    m_ARSIZE   = s1_ARSIZE;
                    m_ARBURST  = s1_ARBURST;
                    m_ARVALID  = s1_ARVALID;
                    s1_ARREADY = m_ARREADY;
                end else begin
                    m_ARID     = {1'b0, s0_ARID};
                    m_ARADDR   = s0_ARADDR;
                    m_ARLEN    = s0_ARLEN;
                    m_ARSIZE   = s0_ARSIZE;
                    m_ARBURST  = s0_ARBURST;
                    m_ARVALID  = s0_ARVALID;
                    s0_ARREADY = m_ARREADY;
                end
            end
            StData: begin
                if (grant_q) begin
                    s1_RID    = m_RID[ID_W-1:0];
                    s1_RDATA  = m_RDATA;
                    s1_RRESP  = m_RRESP;
                    s1_RLAST  = m_RLAST;
                    s1_RVALID = m_RVALID;
                    m_RREADY  = s1_RREADY;
                end else begin
                    s0_RID    = m_RID[ID_W-1:0];
                    s0_RDATA  = m_RDATA;
                    s0_RRESP  = m_RRESP;
                    s0_RLAST  = m_RLAST;
                    s0_RVALID = m_RVALID;
                    m_RREADY  = s0_RREADY;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed self-checking bench for axi4_rd_arbiter.
module tb_axi4_rd_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  s0_ARID, s1_ARID;
    logic [31:0] s0_ARADDR, s1_ARADDR;
    logic [7:0]  s0_ARLEN, s1_ARLEN;
    logic [2:0]  s0_ARSIZE, s1_ARSIZE;
    logic [1:0]  s0_ARBURST, s1_ARBURST;
    logic        s0_ARVALID, s1_ARVALID, s0_ARREADY, s1_ARREADY;
    logic [3:0]  s0_RID, s1_RID;
    logic [31:0] s0_RDATA, s1_RDATA;
    logic [1:0]  s0_RRESP, s1_RRESP;
    logic        s0_RLAST, s1_RLAST, s0_RVALID, s1_RVALID, s0_RREADY, s1_RREADY;
    logic [4:0]  m_ARID, m_RID;
    logic [31:0] m_ARADDR, m_RDATA;
    logic [7:0]  m_ARLEN;
    logic [2:0]  m_ARSIZE, m_ARPROT;
    logic [1:0]  m_ARBURST, m_RRESP;
    logic        m_ARLOCK;
    logic [3:0]  m_ARCACHE, m_ARQOS, m_ARREGION;
    logic        m_ARVALID, m_ARREADY, m_RLAST, m_RVALID, m_RREADY;

    int n_tests = 0;
    int n_fail  = 0;

    // Burst table for s1: 2-cycle RVALID stall, then RREADY low one cycle
    logic        mv_t [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        rr_t [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        ls_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] dt_t [7] = '{32'hB000_0000, 32'h0, 32'h0, 32'hB000_0001,
                              32'hB000_0001, 32'hB000_0002, 32'hB000_0003};

    always #5 ACLK = ~ACLK;

    axi4_rd_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s0_ARID(s0_ARID), .s0_ARADDR(s0_ARADDR), .s0_ARLEN(s0_ARLEN),
        .s0_ARSIZE(s0_ARSIZE), .s0_ARBURST(s0_ARBURST), .s0_ARVALID(s0_ARVALID),
        .s0_ARREADY(s0_ARREADY), .s0_RID(s0_RID), .s0_RDATA(s0_RDATA),
        .s0_RRESP(s0_RRESP), .s0_RLAST(s0_RLAST), .s0_RVALID(s0_RVALID),
        .s0_RREADY(s0_RREADY),
        .s1_ARID(s1_ARID), .s1_ARADDR(s1_ARADDR), .s1_ARLEN(s1_ARLEN),
        .s1_ARSIZE(s1_ARSIZE), .s1_ARBURST(s1_ARBURST), .s1_ARVALID(s1_ARVALID),
        .s1_ARREADY(s1_ARREADY), .s1_RID(s1_RID), .s1_RDATA(s1_RDATA),
        .s1_RRESP(s1_RRESP), .s1_RLAST(s1_RLAST), .s1_RVALID(s1_RVALID),
        .s1_RREADY(s1_RREADY),
        .m_ARID(m_ARID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE),
        .m_ARBURST(m_ARBURST), .m_ARLOCK(m_ARLOCK), .m_ARCACHE(m_ARCACHE),
        .m_ARPROT(m_ARPROT), .m_ARQOS(m_ARQOS), .m_ARREGION(m_ARREGION),
        .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_RID(m_RID),
        .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST),
        .m_RVALID(m_RVALID), .m_RREADY(m_RREADY)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        s0_ARVALID = 0; s1_ARVALID = 0; s0_RREADY = 0; s1_RREADY = 0;
        m_ARREADY = 0; m_RVALID = 0; m_RLAST = 0; m_RDATA = '0; m_RID = '0;
        m_RRESP = '0;
    endtask

    // Single RLAST beat for the granted port; entered just after the edge into DATA
    task automatic finish_single(input bit port, input logic [31:0] d, input string tag);
        m_RVALID = 1; m_RLAST = 1; m_RDATA = d;
        if (port) s1_RREADY = 1; else s0_RREADY = 1;
        @(negedge ACLK);
        check_eq({tag, "_rvalid"}, port ? s1_RVALID : s0_RVALID, 1);
        check_eq({tag, "_rdata"}, port ? s1_RDATA : s0_RDATA, d);
        check_eq({tag, "_rlast"}, port ? s1_RLAST : s0_RLAST, 1);
        check_eq({tag, "_other_rvalid"}, port ? s0_RVALID : s1_RVALID, 0);
        check_eq({tag, "_m_rready"}, m_RREADY, 1);
        step();
        m_RVALID = 0; m_RLAST = 0; s0_RREADY = 0; s1_RREADY = 0;
    endtask

    initial begin
        ARESETn = 0;
        clear_inputs();
        s0_ARID = '0; s0_ARADDR = '0; s0_ARLEN = '0; s0_ARSIZE = 3'd2; s0_ARBURST = 2'd1;
        s1_ARID = '0; s1_ARADDR = '0; s1_ARLEN = '0; s1_ARSIZE = 3'd2; s1_ARBURST = 2'd1;
        s0_ARVALID = 1; s1_ARVALID = 1; m_ARREADY = 1; // must be ignored in reset
        repeat (2) step();
        @(negedge ACLK);
        check_eq("rst_m_arvalid", m_ARVALID, 0);
        check_eq("rst_arready", {s0_ARREADY, s1_ARREADY}, 0);
        check_eq("rst_rvalid", {s0_RVALID, s1_RVALID, m_RREADY}, 0);
        check_eq("rst_last_grant", dut.last_grant_q, 1);
        step();
        clear_inputs();
        ARESETn = 1;

        // Single s0 read
        step();
        s0_ARVALID = 1; s0_ARADDR = 32'h1C00_0000; s0_ARID = 4'h0; m_ARREADY = 1;
        @(negedge ACLK);
        check_eq("t1_arb_latency", m_ARVALID, 0);
        step();
        @(negedge ACLK);
        check_eq("t1_m_arvalid", m_ARVALID, 1);
        check_eq("t1_m_arid", m_ARID, 5'h00);
        check_eq("t1_m_araddr", m_ARADDR, 32'h1C00_0000);
        check_eq("t1_arready", {s0_ARREADY, s1_ARREADY}, 2'b10);
        step();
        s0_ARVALID = 0;
        finish_single(1'b0, 32'h02C0_0000, "t1");
        @(negedge ACLK);
        check_eq("t1_idle_m_rready", m_RREADY, 0);

        // Simultaneous requests straight after reset
        ARESETn = 0;
        step();
        ARESETn = 1;
        s0_ARVALID = 1; s0_ARID = 4'h3; s0_ARADDR = 32'h0000_1000;
        s1_ARVALID = 1; s1_ARID = 4'hA; s1_ARADDR = 32'h0000_2000; m_ARREADY = 1;
        step();
        @(negedge ACLK);
        check_eq("t2_first_arid", m_ARID, RR ? 5'h03 : 5'h1A);
        check_eq("t2_first_addr", m_ARADDR, RR ? 32'h1000 : 32'h2000);
        step();
        if (RR) s0_ARVALID = 0; else s1_ARVALID = 0;
        finish_single(!RR, 32'h1111_0000, "t2a");
        step();
        @(negedge ACLK);
        check_eq("t2_second_arid", m_ARID, RR ? 5'h1A : 5'h03);
        step();
        if (RR) s1_ARVALID = 0; else s0_ARVALID = 0;
        finish_single(RR, 32'h2222_0000, "t2b");

        // s1 burst with stalls; s0 requests during it and must stay blocked
        s1_ARVALID = 1; s1_ARID = 4'h5; s1_ARLEN = 8'd3; s1_ARADDR = 32'h0000_3000;
        step();
        s0_ARVALID = 1; s0_ARID = 4'h1; s0_ARLEN = 8'd3; s0_ARADDR = 32'h0000_4000;
        @(negedge ACLK);
        check_eq("t3_m_arid", m_ARID, 5'h15);
        check_eq("t3_m_arlen", m_ARLEN, 8'd3);
        check_eq("t3_s0_arready", s0_ARREADY, 0);
        step();
        s1_ARVALID = 0; m_ARREADY = 0;
        for (int c = 0; c < 7; c++) begin
            m_RVALID = mv_t[c]; m_RDATA = dt_t[c]; m_RLAST = ls_t[c]; s1_RREADY = rr_t[c];
            @(negedge ACLK);
            check_eq($sformatf("t3_c%0d_rvalid", c), s1_RVALID, mv_t[c]);
            check_eq($sformatf("t3_c%0d_m_rready", c), m_RREADY, rr_t[c]);
            check_eq($sformatf("t3_c%0d_s0_blocked", c), {s0_ARREADY, s0_RVALID}, 0);
            if (mv_t[c]) begin
                check_eq($sformatf("t3_c%0d_rdata", c), s1_RDATA, dt_t[c]);
                check_eq($sformatf("t3_c%0d_rlast", c), s1_RLAST, ls_t[c]);
            end
            step();
        end
        m_RVALID = 0; m_RLAST = 0; s1_RREADY = 0;
        @(negedge ACLK);
        check_eq("t3_idle_after_rlast", {m_ARVALID, s0_ARREADY}, 0);
        step();

        // s0 now granted; SoC holds ARREADY low for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check_eq($sformatf("t4_c%0d_m_arvalid", i), m_ARVALID, 1);
            check_eq($sformatf("t4_c%0d_m_arid", i), m_ARID, 5'h01);
            check_eq($sformatf("t4_c%0d_m_araddr", i), m_ARADDR, 32'h4000);
            check_eq($sformatf("t4_c%0d_s0_arready", i), s0_ARREADY, 0);
            step();
        end
        m_ARREADY = 1;
        @(negedge ACLK);
        check_eq("t4_s0_arready", s0_ARREADY, 1);
        step();
        s0_ARVALID = 0; m_ARREADY = 0;

        // Reset mid-burst on s0
        m_RVALID = 1; m_RLAST = 0; m_RDATA = 32'hAAAA_0000; s0_RREADY = 1;
        @(negedge ACLK);
        check_eq("t5_beat_before_rst", s0_RVALID, 1);
        #2 ARESETn = 0;
        #1;
        check_eq("t5_rst_rvalid", {s0_RVALID, s1_RVALID, m_RREADY}, 0);
        check_eq("t5_rst_ar", {m_ARVALID, s0_ARREADY, s1_ARREADY}, 0);
        check_eq("t5_rst_rdata", s0_RDATA, 0);
        check_eq("t5_rst_last_grant", dut.last_grant_q, 1);
        check_eq("t5_rst_grant", dut.grant_q, 0);
        step();
        clear_inputs();
        s0_ARLEN = 0; s1_ARLEN = 0;
        ARESETn = 1;
        s1_ARVALID = 1; s1_ARID = 4'h2; s1_ARADDR = 32'h0000_5000; m_ARREADY = 1;
        step();
        @(negedge ACLK);
        check_eq("t5_fresh_arid", m_ARID, 5'h12);
        check_eq("t5_fresh_arready", s1_ARREADY, 1);
        step();
        s1_ARVALID = 0;
        finish_single(1'b1, 32'hDEAD_BEEF, "t5");
        @(negedge ACLK);
        check_eq("t5_final_idle", {m_ARVALID, m_RREADY}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
